dac_mode_sequencer: RTL and testbench
=====================================

DAC_MODE_SEQUENCER -- requirements
Module: dac_mode_sequencer

Interface
REQ-001 SHALL have parameter MUTE_CYCLES, default 24000; cycles DAC held muted before reset (1 ms at 24 MHz).
REQ-002 SHALL have parameter RESET_CYCLES, default 240; cycles dac_reset is held with the new config applied.
REQ-003 SHALL have parameter PLL_SETTLE_CYCLES, default 240000; cycles allowed for the PLL to settle after pll_s changes.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 2400; stability window, used only under DAC_SEQ_DEBOUNCE_EN.
REQ-005 clk  in  1  logic clock, 24 MHz; the only clock.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 mcu_44_48  in  1  MCU rate family: 0 = 44.1k, 1 = 48k; asynchronous to clk.
REQ-008 mcu_f  in  2  MCU sample-rate multiple; asynchronous to clk.
REQ-009 mcu_dsd_on  in  1  MCU format: 0 = DSD, 1 = PCM; asynchronous to clk.
REQ-010 mcu_mute  in  1  MCU mute request; asynchronous to clk.
REQ-011 mcu_dac_reset  in  1  MCU DAC reset request; asynchronous to clk.
REQ-012 dac_44_48, dac_f[1:0], dac_dsd  out  1/2/1  applied DAC configuration.
REQ-013 dac_mute  out  1  DAC mute, active-high.
REQ-014 dac_reset  out  1  DAC reset, active-high.
REQ-015 pll_s  out  2  external PLL frequency select.
REQ-016 busy  out  1  high whenever the state is not IDLE.

Function
REQ-017 All MCU inputs SHALL pass through two-flop synchronizers before any use.
REQ-018 The synchronized config SHALL be {mcu_44_48, mcu_f, mcu_dsd_on}. The applied config SHALL be held in registers that drive dac_44_48/dac_f/dac_dsd.
REQ-019 pll_s SHALL be 2'b10 when applied dac_dsd = 0. Otherwise it SHALL be {1'b0, dac_44_48}.
REQ-020 The FSM SHALL have five states: IDLE, MUTE_WAIT, APPLY, PLL_SETTLE, UNMUTE_WAIT.
REQ-021 IDLE -> MUTE_WAIT when the synchronized config differs from the applied config; a change is detected the cycle after the synchronizer output changes.
REQ-022 MUTE_WAIT SHALL last MUTE_CYCLES cycles with sequencer mute = 1, then go to APPLY.
REQ-023 On entry to APPLY, the current synchronized config SHALL be latched into the applied registers. APPLY SHALL last RESET_CYCLES cycles with sequencer reset = 1, then go to PLL_SETTLE.
REQ-024 PLL_SETTLE SHALL last PLL_SETTLE_CYCLES cycles with sequencer reset = 1 and mute = 1, then go to UNMUTE_WAIT.
REQ-025 UNMUTE_WAIT SHALL last MUTE_CYCLES cycles with reset = 0 and mute = 1, then go to IDLE.
REQ-026 A single shared down-counter SHALL time every state: it loads N-1 on state entry and the state exits when the counter reaches 0, so each state lasts exactly N cycles; every parameter value SHALL be at least 1.
REQ-027 Config changes outside IDLE SHALL NOT restart or alter the sequence. On return to IDLE, a pending difference SHALL start a new sequence on the next cycle.
REQ-028 dac_mute SHALL equal sequencer mute OR synchronized mcu_mute, registered.
REQ-029 dac_reset SHALL equal sequencer reset OR synchronized mcu_dac_reset, registered; mcu_dac_reset SHALL NOT affect the FSM.

Reset
REQ-030 While reset is high, outputs SHALL be: dac_mute = 1, dac_reset = 1, dac_44_48 = 0, dac_f = 00, dac_dsd = 1, pll_s = 00, busy = 1.
REQ-031 Reset SHALL place the FSM in APPLY, so that a full power-up sequence APPLY -> PLL_SETTLE -> UNMUTE_WAIT -> IDLE runs with the synchronized config.
REQ-032 Reset asserted mid-sequence SHALL abort the sequence immediately, asynchronously.

Configuration
REQ-033 With DAC_SEQ_DEBOUNCE_EN defined, IDLE SHALL leave only after the synchronized config has differed from the applied config and stayed unchanged for DEBOUNCE_CYCLES consecutive cycles; any change during the window SHALL restart the window.
REQ-034 Without DAC_SEQ_DEBOUNCE_EN, REQ-021 timing SHALL apply and no debounce counter SHALL exist.

Structure
REQ-035 The dac_cfg_t struct {sel_48, f[1:0], pcm} and the pll_s mapping function SHALL live in package common.
REQ-036 The two-flop synchronizer SHALL be sub-module dac_seq_sync, parameterized by width, and instantiated once for all five MCU inputs.

Verification (parameters MUTE=4, RESET=2, PLL=8, DEBOUNCE=3)
REQ-037 Release reset with mcu_dsd_on = 1 and mcu_44_48 = 1 -> dac_reset = 1 for 10 cycles, dac_mute = 1 for 14 cycles, then pll_s = 01 and busy = 0.
REQ-038 In IDLE, change mcu_f 00 -> 10 -> dac_mute rises 3 edges later; dac_f = 10 when dac_reset rises; total busy = 18 cycles.
REQ-039 Set mcu_dsd_on = 0 -> pll_s = 10 and dac_dsd = 0 on entry to APPLY, never before dac_mute = 1.
REQ-040 Toggle mcu_44_48 during PLL_SETTLE -> current sequence completes unchanged, and a second sequence starts 1 cycle after IDLE.
REQ-041 Assert mcu_mute in IDLE -> dac_mute = 1 after 3 edges, busy stays 0. Assert reset mid-PLL_SETTLE -> REQ-030 values immediately.
REQ-042 With DAC_SEQ_DEBOUNCE_EN, a 2-cycle glitch on mcu_f -> no sequence starts; a 3-cycle-stable change -> sequence starts.

Source files
------------

// File: rtl/dac_mode_sequencer_pkg.sv
// dac_mode_sequencer_pkg: package common, holding the DAC config struct, sequencer states and the PLL select mapping.
package common;
    typedef struct packed {
        logic       sel_48;
        logic [1:0] f;
        logic       pcm;
    } dac_cfg_t;

    typedef enum logic [2:0] {IDLE, MUTE_WAIT, APPLY, PLL_SETTLE, UNMUTE_WAIT} seq_state_t;

    localparam dac_cfg_t CFG_RST = 4'b0001;

    function automatic logic [1:0] pll_sel(input dac_cfg_t c);
        return c.pcm ? {1'b0, c.sel_48} : 2'b10;
    endfunction
endpackage

// File: rtl/dac_mode_sequencer_sync.sv
// dac_seq_sync: two-flop synchronizer bank for asynchronous MCU control lines.
module dac_seq_sync #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/dac_mode_sequencer.sv
// dac_mode_sequencer: mute -> reset/apply -> PLL settle -> unmute sequencing of DAC config changes.
// Optional DAC_SEQ_DEBOUNCE_EN requires a changed config to hold stable before a sequence starts.
module dac_mode_sequencer
    import common::*;
#(
    parameter int MUTE_CYCLES       = 24000,
    parameter int RESET_CYCLES      = 240,
    parameter int PLL_SETTLE_CYCLES = 240000,
    parameter int DEBOUNCE_CYCLES   = 2400
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mcu_44_48,
    input  logic [1:0] mcu_f,
    input  logic       mcu_dsd_on,
    input  logic       mcu_mute,
    input  logic       mcu_dac_reset,
    output logic       dac_44_48,
    output logic [1:0] dac_f,
    output logic       dac_dsd,
    output logic       dac_mute,
    output logic       dac_reset,
    output logic [1:0] pll_s,
    output logic       busy
);
    localparam int MAX_A = (MUTE_CYCLES > RESET_CYCLES) ? MUTE_CYCLES : RESET_CYCLES;
    localparam int MAX_N = (MAX_A > PLL_SETTLE_CYCLES) ? MAX_A : PLL_SETTLE_CYCLES;
    localparam int CW    = $clog2(MAX_N + 1);

    if (MUTE_CYCLES < 1 || RESET_CYCLES < 1 || PLL_SETTLE_CYCLES < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("dac_mode_sequencer: every cycle-count parameter must be at least 1");
    end

    logic [5:0]    w_sync;
    dac_cfg_t      w_cfg;
    logic          w_mute;
    logic          w_rst;
    logic          w_start;
    logic          w_done;
    seq_state_t    w_next;
    logic [CW-1:0] w_load;

    seq_state_t    r_state;
    logic [CW-1:0] r_cnt;
    dac_cfg_t      r_cfg;
    logic          r_por;
    logic          r_mute;
    logic          r_rst;

    dac_seq_sync #(
        .WIDTH  (6),
        .RST_VAL({CFG_RST, 2'b10})
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .i_d  ({mcu_44_48, mcu_f, mcu_dsd_on, mcu_mute, mcu_dac_reset}),
        .o_q  (w_sync)
    );

    assign w_cfg  = w_sync[5:2];
    assign w_mute = w_sync[1];
    assign w_rst  = w_sync[0];

`ifdef DAC_SEQ_DEBOUNCE_EN
    // Run length of the current synchronized config, saturated at the window length.
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 2);
    dac_cfg_t      r_prev;
    logic [DW-1:0] r_db;
    logic [DW-1:0] w_len;

    assign w_len   = (w_cfg == r_prev) ? r_db + DW'(1) : DW'(1);
    assign w_start = (w_cfg != r_cfg) && (w_len >= DW'(DEBOUNCE_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= CFG_RST;
            r_db   <= '0;
        end else begin
            r_prev <= w_cfg;
            r_db   <= (w_len >= DW'(DEBOUNCE_CYCLES)) ? DW'(DEBOUNCE_CYCLES) : w_len;
        end
    end
`else
    assign w_start = w_cfg != r_cfg;
`endif

    assign w_done = r_cnt == '0;

    always_comb begin
        w_next = (r_state == IDLE)       ? (w_start ? MUTE_WAIT : IDLE) :
                 !w_done                 ? r_state :
                 (r_state == MUTE_WAIT)  ? APPLY :
                 (r_state == APPLY)      ? PLL_SETTLE :
                 (r_state == PLL_SETTLE) ? UNMUTE_WAIT : IDLE;
        w_load = (w_next == APPLY)      ? CW'(RESET_CYCLES - 1) :
                 (w_next == PLL_SETTLE) ? CW'(PLL_SETTLE_CYCLES - 1) :
                 (w_next == IDLE)       ? '0 : CW'(MUTE_CYCLES - 1);
    end

    // After reset the applied config tracks the synchronizer while the DAC is held in reset,
    // so the power-up sequence ends with the MCU's config rather than the reset default.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= APPLY;
            r_cnt   <= CW'(RESET_CYCLES - 1);
            r_cfg   <= CFG_RST;
            r_por   <= 1'b1;
            r_mute  <= 1'b1;
            r_rst   <= 1'b1;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state || r_state == IDLE) ? w_load : r_cnt - CW'(1);
            if ((r_por && (r_state == APPLY || r_state == PLL_SETTLE)) || (w_next == APPLY && r_state != APPLY))
                r_cfg <= w_cfg;
            if (w_next == UNMUTE_WAIT)
                r_por <= 1'b0;
            r_mute  <= (w_next != IDLE) | w_mute;
            r_rst   <= (w_next == APPLY || w_next == PLL_SETTLE) | w_rst;
        end
    end

    assign dac_44_48 = r_cfg.sel_48;
    assign dac_f     = r_cfg.f;
    assign dac_dsd   = r_cfg.pcm;
    assign dac_mute  = r_mute;
    assign dac_reset = r_rst;
    assign pll_s     = pll_sel(r_cfg);
    assign busy      = r_state != IDLE;
endmodule

// File: tb/tb_dac_mode_sequencer.sv
// tb_dac_mode_sequencer: directed and randomized checks of dac_mode_sequencer against a timeline model.
module tb_dac_mode_sequencer;
    localparam int M = 4, R = 2, P = 8, D = 3, TOT = 2 * M + R + P;
`ifdef DAC_SEQ_DEBOUNCE_EN
    localparam int DEB = D;
`else
    localparam int DEB = 1;
`endif
    localparam int GLITCH_BUSY = (DEB > 2) ? 0 : TOT;

    logic       clk = 1'b0, reset = 1'b1;
    logic       mcu_44_48 = 1'b0, mcu_dsd_on = 1'b1, mcu_mute = 1'b0, mcu_dac_reset = 1'b0;
    logic [1:0] mcu_f = 2'b00;
    logic       dac_44_48, dac_dsd, dac_mute, dac_reset, busy;
    logic [1:0] dac_f, pll_s;
    logic [8:0] obs;
    int         checks = 0, errors = 0;

    // Model: sequence position m_t (-1 = idle), applied config, two-cycle input delay line.
    int         m_t, m_run;
    bit         m_por;
    logic [3:0] m_cfg;
    logic [5:0] m_s1, m_sync;
    logic       m_mreq, m_rreq;

    always #5 clk = ~clk;

    assign obs = {busy, dac_mute, dac_reset, dac_44_48, dac_f, dac_dsd, pll_s};

    dac_mode_sequencer #(
        .MUTE_CYCLES      (M),
        .RESET_CYCLES     (R),
        .PLL_SETTLE_CYCLES(P),
        .DEBOUNCE_CYCLES  (D)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mcu_44_48    (mcu_44_48),
        .mcu_f        (mcu_f),
        .mcu_dsd_on   (mcu_dsd_on),
        .mcu_mute     (mcu_mute),
        .mcu_dac_reset(mcu_dac_reset),
        .dac_44_48    (dac_44_48),
        .dac_f        (dac_f),
        .dac_dsd      (dac_dsd),
        .dac_mute     (dac_mute),
        .dac_reset    (dac_reset),
        .pll_s        (pll_s),
        .busy         (busy)
    );

    task automatic model_reset();
        m_t = M; m_por = 1; m_cfg = 4'b0001; m_s1 = 6'b000110; m_sync = 6'b000110;
        m_run = 1; m_mreq = 1'b0; m_rreq = 1'b0;
    endtask

    task automatic tick();
        logic [5:0] in_cur, old;
        in_cur = {mcu_44_48, mcu_f, mcu_dsd_on, mcu_mute, mcu_dac_reset};
        @(posedge clk);
        #1;
        old = m_sync;
        if (m_t >= 0) begin
            if (m_por && m_t >= M && m_t < M + R + P) m_cfg = old[5:2];
            m_t++;
            if (m_t == M) m_cfg = old[5:2];
            if (m_t == TOT) begin m_t = -1; m_por = 0; end
        end else if (old[5:2] != m_cfg && m_run >= DEB) begin
            m_t = 0;
        end
        m_run = (m_s1[5:2] == old[5:2]) ? m_run + 1 : 1;
        m_sync = m_s1;
        m_s1 = in_cur;
        m_mreq = old[1];
        m_rreq = old[0];
    endtask

    function automatic logic [8:0] expv();
        logic b, r;
        b = m_t >= 0;
        r = m_t >= M && m_t < M + R + P;
        return {b, b | m_mreq, r | m_rreq, m_cfg, m_cfg[0] ? {1'b0, m_cfg[3]} : 2'b10};
    endfunction

    task automatic test_reset();
        mcu_44_48 = 1'b1; mcu_f = 2'b00; mcu_dsd_on = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== 9'b111000100) begin
            errors++; $display("FAIL reset_values got %b want %b", obs, 9'b111000100);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_powerup();
        int nr, nm;
        nr = int'(dac_reset); nm = int'(dac_mute);
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL powerup_model cyc %0d got %b want %b", i, obs, expv()); end
            nr += int'(dac_reset); nm += int'(dac_mute);
        end
        checks++;
        if (nr != R + P) begin errors++; $display("FAIL powerup_reset_len got %0d want %0d", nr, R + P); end
        checks++;
        if (nm != R + P + M) begin errors++; $display("FAIL powerup_mute_len got %0d want %0d", nm, R + P + M); end
        checks++;
        if ({pll_s, busy} !== 3'b010) begin errors++; $display("FAIL powerup_end got %b want 010", {pll_s, busy}); end
    endtask

    task automatic test_cfg_change();
        int rose_at, nbusy;
        bit started, prev_rst;
        rose_at = -1; nbusy = 0; started = 0; prev_rst = dac_reset;
        mcu_f = 2'b10;
        for (int i = 1; i <= 60; i++) begin
            tick();
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL cfg_model cyc %0d got %b want %b", i, obs, expv()); end
            if (dac_mute && rose_at < 0) rose_at = i;
            if (dac_reset && !prev_rst) begin
                checks++;
                if (dac_f !== 2'b10) begin errors++; $display("FAIL cfg_f_at_reset got %b want 10", dac_f); end
            end
            prev_rst = dac_reset;
            nbusy += int'(busy);
            if (busy) started = 1;
            else if (started) break;
        end
        checks++;
        if (rose_at != 2 + DEB) begin errors++; $display("FAIL cfg_mute_latency got %0d want %0d", rose_at, 2 + DEB); end
        checks++;
        if (nbusy != TOT) begin errors++; $display("FAIL cfg_busy_len got %0d want %0d", nbusy, TOT); end
    endtask

    task automatic test_dsd();
        bit started, seen;
        started = 0; seen = 0;
        mcu_dsd_on = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL dsd_model cyc %0d got %b want %b", i, obs, expv()); end
            if (dac_reset) seen = 1;
            checks++;
            if ({dac_dsd, pll_s} !== (seen ? 3'b010 : 3'b101))
                begin errors++; $display("FAIL dsd_apply cyc %0d got %b want %b", i, {dac_dsd, pll_s}, seen ? 3'b010 : 3'b101); end
            if (busy) started = 1;
            else if (started) break;
        end
    endtask

    task automatic test_change_during_pll();
        int nr;
        bit started;
        nr = 0; started = 0;
        mcu_44_48 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL pll_model cyc %0d got %b want %b", i, obs, expv()); end
            nr += int'(dac_reset);
            if (nr == 4) mcu_44_48 = 1'b1;
            if (busy) started = 1;
            else if (started) break;
        end
        checks++;
        if ({busy, dac_44_48} !== 2'b00) begin errors++; $display("FAIL pll_first_cfg got %b want 00", {busy, dac_44_48}); end
        tick();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL pll_restart got %b want 1", busy); end
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL pll2_model cyc %0d got %b want %b", i, obs, expv()); end
        end
        checks++;
        if ({busy, dac_44_48} !== 2'b01) begin errors++; $display("FAIL pll_second_cfg got %b want 01", {busy, dac_44_48}); end
    endtask

    task automatic test_mute_req();
        mcu_mute = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if ({busy, dac_mute} !== {1'b0, 1'(i >= 3)}) begin errors++; $display("FAIL mute_req cyc %0d got %b want %b", i, {busy, dac_mute}, {1'b0, 1'(i >= 3)}); end
        end
        mcu_mute = 1'b0; mcu_dac_reset = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if ({busy, dac_reset} !== {1'b0, 1'(i >= 3)}) begin errors++; $display("FAIL reset_req cyc %0d got %b want %b", i, {busy, dac_reset}, {1'b0, 1'(i >= 3)}); end
        end
        mcu_dac_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL req_release cyc %0d got %b want %b", i, obs, expv()); end
        end
    endtask

    task automatic test_glitch();
        int nb;
        nb = 0;
        mcu_f = 2'b01;
        tick(); tick();
        mcu_f = 2'b10;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL glitch_model cyc %0d got %b want %b", i, obs, expv()); end
            nb += int'(busy);
        end
        checks++;
        if (nb != GLITCH_BUSY) begin errors++; $display("FAIL glitch_busy got %0d want %0d", nb, GLITCH_BUSY); end
        nb = 0;
        mcu_f = 2'b01;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL stable_model cyc %0d got %b want %b", i, obs, expv()); end
            nb += int'(busy);
        end
        checks++;
        if ({nb, dac_f} !== {TOT, 2'b01}) begin errors++; $display("FAIL stable_seq got %0d/%b want %0d/01", nb, dac_f, TOT); end
    endtask

    task automatic test_reset_mid();
        int nr;
        nr = 0;
        mcu_44_48 = 1'b0;
        for (int i = 0; i < 40 && nr < 4; i++) begin
            tick();
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL mid_model cyc %0d got %b want %b", i, obs, expv()); end
            nr += int'(dac_reset);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs !== 9'b111000100) begin errors++; $display("FAIL mid_reset_values got %b want %b", obs, 9'b111000100); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL mid_powerup cyc %0d got %b want %b", i, obs, expv()); end
        end
        checks++;
        if ({busy, dac_44_48, dac_f, dac_dsd} !== 5'b00010) begin errors++; $display("FAIL mid_end got %b want 00010", {busy, dac_44_48, dac_f, dac_dsd}); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 24) == 0) {mcu_44_48, mcu_f, mcu_dsd_on} = 4'($urandom);
            if ($urandom_range(0, 9) == 0) mcu_mute = ~mcu_mute;
            if ($urandom_range(0, 9) == 0) mcu_dac_reset = ~mcu_dac_reset;
            tick();
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL random_model cyc %0d got %b want %b", i, obs, expv()); end
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_cfg_change();
        test_dsd();
        test_change_during_pll();
        test_mute_req();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
